// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for an N_DIGITS common-anode seven-segment
//   display. A 32-bit word, decimal-point mask and error flag are captured
//   into shadow registers on a load strobe. The driver then scans the digits,
//   holding each one for REFRESH_DIV clock cycles.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   load       in   single-cycle strobe; captures data_in, dp_in, err_in
//   data_in    in   value to display; nibble k drives digit k (digit 0 rightmost)
//   dp_in      in   decimal-point request per digit, active-high
//   err_in     in   when captured high, every digit shows the dash code
//   blank_mask in   live per-digit force-blank, active-high
//   digit      out  code to the seg decoder: 0x00..0x0F hex, 0x10 dash
//   an         out  anode enables, active-low, at most one bit low
//   dp         out  decimal point, active-low
//   tick       out  one-cycle pulse each time the scan index advances
module seg_scan_driver #(
   parameter int N_DIGITS    = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int LZ_BLANK    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] data_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  err_in,
   input  logic [N_DIGITS-1:0]   blank_mask,
   output logic [4:0]            digit,
   output logic [N_DIGITS-1:0]   an,
   output logic                  dp,
   output logic                  tick
);

   localparam int IW = $clog2(N_DIGITS);
   localparam int CW = $clog2(REFRESH_DIV);

   localparam logic [4:0] DASH = 5'h10;

   logic [CW-1:0]         cnt;
   logic                  term;
   logic [IW-1:0]         idx;
   logic [4*N_DIGITS-1:0] sh_data;
   logic [N_DIGITS-1:0]   sh_dp;
   logic                  sh_err;

   logic                  blanked;
   logic                  zero_above;
   logic [3:0]            nib;
   logic [4:0]            digit_nx;
   logic [N_DIGITS-1:0]   an_nx;
   logic                  dp_nx;

   assign term = (cnt == CW'(REFRESH_DIV - 1));

   // Refresh counter, scan index and tick register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         idx  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= term;
         if (term) begin
            cnt <= '0;
            idx <= idx + IW'(1);
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Shadow registers; load never touches the scan timing
   always_ff @(posedge clk) begin
      if (reset) begin
         sh_data <= '0;
         sh_dp   <= '0;
         sh_err  <= 1'b0;
      end else if (load) begin
         sh_data <= data_in;
         sh_dp   <= dp_in;
         sh_err  <= err_in;
      end
   end

   // Next output values for the current index
   always_comb begin
      nib        = sh_data[{idx, 2'b00} +: 4];
      // Nibbles idx..top are all zero: this digit is a leading zero
      zero_above = ((sh_data >> {idx, 2'b00}) == '0);
      blanked    = blank_mask[idx];
      if ((LZ_BLANK != 0) && !sh_err && (idx != '0) && zero_above)
         blanked = 1'b1;

      digit_nx = sh_err ? DASH : {1'b0, nib};
      an_nx    = '1;
      dp_nx    = 1'b1;
      if (!blanked) begin
         an_nx = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx);
         dp_nx = ~sh_dp[idx];
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         digit <= '0;
         an    <= '1;
         dp    <= 1'b1;
      end else begin
         digit <= digit_nx;
         an    <= an_nx;
         dp    <= dp_nx;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
//   Scoreboard bench for seg_scan_driver with REFRESH_DIV=4. Two instances
//   share the stimulus: one with leading-zero blanking, one without. The
//   driver pushes the expected outputs for each edge into per-instance
//   queues; a monitor pops and compares one entry per cycle after the edge.
module tb_seg_scan_driver;

   localparam int R = 4;
   localparam int N = 8;

   typedef struct packed {
      logic [4:0] digit;
      logic [7:0] an;
      logic       dp;
      logic       tick;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [31:0] data_in = '0;
   logic [7:0]  dp_in = '0;
   logic        err_in = 1'b0;
   logic [7:0]  blank_mask = '0;

   logic [4:0]  digit_a, digit_b;
   logic [7:0]  an_a, an_b;
   logic        dp_a, dp_b, tick_a, tick_b;

   obs_t qa[$];
   obs_t qb[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit done     = 0;

   // Reference model state
   int          n_edges = 0;
   logic [31:0] m_data = '0;
   logic [7:0]  m_dp = '0;
   logic        m_err = 1'b0;

   always #5 clk = ~clk;

   seg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(R), .LZ_BLANK(1)) dut_a (
      .clk(clk), .reset(reset), .load(load), .data_in(data_in), .dp_in(dp_in),
      .err_in(err_in), .blank_mask(blank_mask),
      .digit(digit_a), .an(an_a), .dp(dp_a), .tick(tick_a)
   );

   seg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(R), .LZ_BLANK(0)) dut_b (
      .clk(clk), .reset(reset), .load(load), .data_in(data_in), .dp_in(dp_in),
      .err_in(err_in), .blank_mask(blank_mask),
      .digit(digit_b), .an(an_b), .dp(dp_b), .tick(tick_b)
   );

   // Expected outputs after the n-th edge since reset release, given the
   // shadow contents held before that edge and the live blank mask.
   function automatic obs_t model(int n, logic [31:0] d, logic [7:0] dpv,
                                  logic e, logic [7:0] mask, bit lz);
      obs_t o;
      int   i;
      int   sig;
      logic [3:0] nibv;
      bit   lit;
      i   = ((n - 1) / R) % N;
      sig = 1;
      for (int k = 0; k < N; k++)
         if (((d >> (4 * k)) & 32'hF) != 0) sig = k + 1;
      nibv = 4'((d >> (4 * i)) & 32'hF);
      lit  = !mask[i] && (e || !lz || (i < sig));
      o.digit = e ? 5'h10 : {1'b0, nibv};
      o.an    = lit ? ~(8'h01 << i) : 8'hFF;
      o.dp    = lit ? ~dpv[i] : 1'b1;
      o.tick  = ((n % R) == 0);
      return o;
   endfunction

   task automatic step(input bit rst, input bit ld, input logic [31:0] d,
                       input logic [7:0] dpv, input bit e, input logic [7:0] mask);
      obs_t rv;
      @(negedge clk);
      reset      = rst;
      load       = ld;
      data_in    = d;
      dp_in      = dpv;
      err_in     = e;
      blank_mask = mask;
      if (rst) begin
         rv = '{digit: 5'h00, an: 8'hFF, dp: 1'b1, tick: 1'b0};
         qa.push_back(rv);
         qb.push_back(rv);
         n_edges = 0;
         m_data  = '0;
         m_dp    = '0;
         m_err   = 1'b0;
      end else begin
         n_edges++;
         qa.push_back(model(n_edges, m_data, m_dp, m_err, mask, 1'b1));
         qb.push_back(model(n_edges, m_data, m_dp, m_err, mask, 1'b0));
         if (ld) begin
            m_data = d;
            m_dp   = dpv;
            m_err  = e;
         end
      end
   endtask

   // Cycles with no load; data inputs carry noise that must be ignored
   task automatic idle(input int k, input logic [7:0] mask);
      for (int j = 0; j < k; j++)
         step(0, 0, $urandom, 8'($urandom), 1'($urandom), mask);
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] dpv,
                          input bit e, input logic [7:0] mask);
      step(0, 1, d, dpv, e, mask);
   endtask

   task automatic check(input string name, input obs_t act, input obs_t req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual digit=%h an=%h dp=%b tick=%b required digit=%h an=%h dp=%b tick=%b",
                  name, cyc, act.digit, act.an, act.dp, act.tick,
                  req.digit, req.an, req.dp, req.tick);
      end
   endtask

   // Monitor: one observation per instance per cycle
   initial begin
      obs_t ea, eb;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (qa.size() != 0 && qb.size() != 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            check("lz_on",  {digit_a, an_a, dp_a, tick_a}, ea);
            check("lz_off", {digit_b, an_b, dp_b, tick_b}, eb);
         end
      end
   end

   initial begin : stim
      // Reset, then idle
      step(1, 0, '0, '0, 0, '0);
      step(1, 0, '0, '0, 0, '0);
      idle(8, 8'h00);
      // Full scans of a mixed word
      do_load(32'h1234ABCD, 8'h00, 0, 8'h00);
      idle(36, 8'h00);
      // Leading-zero blanking
      do_load(32'h000000A5, 8'h00, 0, 8'h00);
      idle(36, 8'h00);
      do_load(32'h00000000, 8'h00, 0, 8'h00);
      idle(36, 8'h00);
      // Error display, then with forced blanking
      do_load(32'h00000000, 8'h00, 1, 8'h00);
      idle(36, 8'h00);
      idle(36, 8'h0F);
      // Decimal point on digit 2
      do_load(32'h00000123, 8'h04, 0, 8'h00);
      idle(36, 8'h00);
      // Reset mid-period while index 5 is displayed
      while (!(((n_edges / R) % N == 5) && (n_edges % R == 1)))
         idle(1, 8'h00);
      step(1, 0, '0, '0, 0, '0);
      idle(12, 8'h00);
      // Back-to-back loads: last one wins
      do_load(32'h11111111, 8'hFF, 1, 8'h00);
      do_load(32'h87654321, 8'h81, 0, 8'h00);
      idle(10, 8'h00);
      // Load coinciding with a tick edge
      while (((n_edges + 1) % R) != 0)
         idle(1, 8'h00);
      do_load(32'hFEDC0009, 8'h20, 0, 8'h00);
      idle(40, 8'h00);
      // Randomized traffic
      for (int j = 0; j < 800; j++) begin
         bit          rst, ld, e;
         logic [31:0] d;
         logic [7:0]  mask;
         rst  = ($urandom_range(0, 149) == 0);
         ld   = ($urandom_range(0, 9) == 0);
         d    = $urandom >> $urandom_range(0, 31);
         e    = ($urandom_range(0, 7) == 0);
         mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         step(rst, ld, d, 8'($urandom), e, mask);
      end
      // Drain the scoreboard, bounded
      for (int j = 0; j < 10 && (qa.size() != 0 || qb.size() != 0); j++)
         @(negedge clk);
      n_checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual %0d/%0d entries left required 0", qa.size(), qb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for the 8-digit, common-anode seven-segment display on the I/O board.
- Latches a 32-bit word from the MIPS I/O port on a load strobe and cycles through its eight nibbles at a programmable refresh rate.
- Drives the 5-bit digit code into the downstream hex-to-segment decoder, together with active-low anode enables and the decimal point.
- Digit code 5'h10 is the dash glyph; it is used for error display.

Parameters:
- N_DIGITS, 8, number of digits scanned; fixed to 8 for this board. Drives the width of an, dp_in and blank_mask.
- REFRESH_DIV, 100000, clock cycles each digit is held; 1 kHz per digit at 100 MHz. Legal range 2..2^20.
- LZ_BLANK, 1, when 1, leading zero digits are blanked. Digit 0 is never blanked by this rule.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe; captures data_in, dp_in, err_in
- data_in  in  32  value to display; nibble k drives digit k (digit 0 is rightmost)
- dp_in  in  8  decimal-point request per digit, active-high
- err_in  in  1  when captured high, all digits show the dash code
- blank_mask  in  8  live (not latched) per-digit force-blank, active-high
- digit  out  5  code to the seg decoder: 5'h00..5'h0F = hex nibble, 5'h10 = dash
- an  out  8  anode enables, active-low, at most one bit low
- dp  out  1  decimal point, active-low
- tick  out  1  one-cycle pulse each time the scan index advances

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; all state changes on the clk rising edge.
- Reset values:
  - refresh counter = 0, scan index = 0, shadow data = 0, shadow dp = 0, shadow err = 0.
  - Outputs: an = 8'hFF, digit = 5'h00, dp = 1, tick = 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Asserts an internal terminal tick on the cycle it equals REFRESH_DIV-1.
  - On that tick the scan index increments and wraps 7 -> 0. The tick output register is 1 on the following cycle.
- Load:
  - When load=1, shadow registers take data_in, dp_in and err_in at the edge.
  - load has no effect on the counter or scan index. Back-to-back loads: last one wins.
- Output registers, updated every cycle from the current index i and the shadow state:
  - Blanking: digit i is blanked if blank_mask[i]=1. With LZ_BLANK=1 and shadow err=0, it is also blanked if i>0 and shadow nibbles i..7 are all zero.
  - an: blanked -> an=8'hFF; otherwise an = ~(1<<i).
  - digit: shadow err=1 -> 5'h10; otherwise {1'b0, shadow nibble i}. Driven even when blanked.
  - dp = ~(shadow dp[i]) when not blanked; 1 when blanked.
- Latency:
  - load at edge t -> shadow valid after t -> outputs reflect the new data after edge t+1.
  - Index change at edge t -> an/digit for the new index after edge t+1.
- Error display: err blocks leading-zero blanking, so all 8 digits show a dash. blank_mask still applies.
- Reset during a scan: counter, index, shadow and outputs return to reset values on the same edge. Scanning restarts at digit 0 and the first refresh period is full length.
- Simultaneous load and tick: both take effect on the same edge. The new index is shown with the new data one cycle later.
- Values: data 0 with LZ_BLANK=1 shows a single "0" on digit 0. LZ_BLANK=0 shows all eight digits.

Test Plan (REFRESH_DIV=4 for simulation):
- Reset for 2 cycles, then release -> an=8'hFF during reset. First post-reset cycle: an=8'hFE, digit=0, dp=1. tick first pulses 4 cycles after release.
- load data_in=32'h1234ABCD, dp_in=0 -> over one scan digit/an sequence is D/FE, C/FD, B/FB, A/F7, 4/EF, 3/DF, 2/BF, 1/7F, then wraps to D/FE. Each digit is held 4 cycles.
- load data_in=32'h000000A5, LZ_BLANK=1 -> digits 0,1 lit (5, A). Indices 2..7 give an=8'hFF. data_in=0 -> only digit 0 lit, digit=0.
- load err_in=1, data_in=0 -> every index gives digit=5'h10 and an active. Setting blank_mask=8'h0F -> indices 0..3 give an=8'hFF.
- dp_in=8'h04 with data 32'h00000123 -> dp=0 only while index=2; otherwise dp=1.
- Assert reset while index=5, mid-period -> next cycle index=0, an=8'hFF. After release, digit 0 is held a full 4 cycles. Issue load in the same cycle as a tick -> the new value appears on the new index one cycle later.
